second_pulse_ctrl: RTL and testbench
====================================

# second_pulse_ctrl

Control-side counterpart of the countdown display: generates the `one_second_pulse` strobe that the display timer consumes and issues its clear. It watches the returned `game_finished` flag to stop strobing. Start and pause pushbuttons run a four-state FSM (idle, running, paused, expired). The block sits between the board keys and the countdown/7-segment display logic, on the same clock.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per strobe; must be ≥ 2. Use 10 in simulation.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: one clock; reset is asynchronous and active-low.
- `start_key_n`, input, 1: start/restart pushbutton; active-low; asynchronous to `clk`.
- `pause_key_n`, input, 1: pause/resume pushbutton; active-low; asynchronous.
- `game_finished`, input, 1: high when the countdown has reached 00; from the display timer.
- `one_second_pulse`, output, 1: one-cycle strobe, once every `CLK_HZ` running cycles.
- `timer_clear`, output, 1: one-cycle active-high clear to the countdown (reloads 30, drops `game_finished`).
- `running`, output, 1: high in RUNNING.
- `paused`, output, 1: high in PAUSED.
- `expired`, output, 1: high in EXPIRED.

## Operation
- **Key synchronisation**
  - Each key passes through a 2-flop synchroniser, then a press-edge detector (1→0 on the synchronised level).
  - Each press produces exactly one single-cycle event: `start_ev` or `pause_ev`.
  - Holding a key produces no further events.
- **Prescaler**
  - Width `$clog2(CLK_HZ)`.
  - Increments only in RUNNING with no event in that cycle; wraps from `CLK_HZ-1` to 0.
  - Holds its value in PAUSED; clears to 0 on every restart.
- **States**
  - IDLE (after reset): no strobes; `pause_ev` is ignored; `start_ev` → restart.
  - RUNNING:
    - `game_finished` → EXPIRED.
    - Otherwise `start_ev` → restart.
    - Otherwise `pause_ev` → PAUSED.
    - Otherwise count.
  - PAUSED: `start_ev` → restart; `pause_ev` → RUNNING, resuming from the held prescaler value.
  - EXPIRED: no strobes; `pause_ev` is ignored; `start_ev` → restart.
- **Restart:** `timer_clear` = 1 for one cycle; prescaler ← 0; state ← RUNNING.
- **Priority** in any cycle: `game_finished` (RUNNING only) > `start_ev` > `pause_ev`. Simultaneous start and pause presses act as start only.
- **Strobe generation:** `one_second_pulse` is registered. It goes high the cycle after RUNNING sees prescaler = `CLK_HZ-1` with no event and `game_finished` low.
- **Clear window:** `game_finished` is ignored in the cycle `timer_clear` is high, and in the cycle after it. This allows the downstream clear to propagate.
- **Status outputs:** `running`, `paused` and `expired` decode the state register. They are one-hot or all-zero (all zero in IDLE).

## Timing
- **Reset values:** state IDLE; prescaler 0; both synchroniser chains and edge registers at 1 (released level). All outputs 0.
- **Key latency:** key falling edge to event takes 3 clk edges (2 synchroniser + 1 edge register). The state/`timer_clear` update lands on the next edge.
- **Strobe period:** after a restart edge, the first `one_second_pulse` is high `CLK_HZ` cycles later. Subsequent strobes are exactly `CLK_HZ` cycles apart while running.
- **Pause/resume:** total running cycles between strobes stay `CLK_HZ`, however long the pause lasts.
- **Pause on the wrap cycle:** a `pause_ev` coinciding with prescaler = `CLK_HZ-1` suppresses that strobe. The prescaler holds at `CLK_HZ-1`; the strobe is issued on the first running cycle after resume.
- **Expiry:** once `game_finished` is seen in RUNNING, no further strobe is issued; EXPIRED holds until `start_ev` or reset.
- **Reset mid-operation:** asynchronous return to the reset values; a pending strobe or clear is dropped.

## Test plan
1. Reset, `CLK_HZ`=10, press start → `timer_clear` high 1 cycle, `running`=1. Strobes at cycles +10, +20, +30 after clear, each exactly 1 cycle wide.
2. Running with prescaler at 4: press pause, hold 37 cycles, press pause again → `paused`=1 throughout, no strobe. The next strobe comes after 6 further running cycles.
3. Drive `game_finished`=1 two cycles after a strobe → `expired`=1 on the next edge, no more strobes. Press start → `timer_clear` pulse, back to RUNNING, first strobe 10 cycles later.
4. Press start and pause on the same cycle while PAUSED → restart only (`timer_clear`=1, `running`=1, prescaler 0).
5. Hold start low for 50 cycles → exactly one `timer_clear`. A pause press in IDLE → no state change.
6. Assert `rst_n`=0 for 1 cycle mid-count → all outputs 0 immediately, state IDLE, no strobe until the next start.

Source files
------------

// File: rtl/second_pulse_ctrl.sv
// second_pulse_ctrl: start/pause key FSM that generates the one-second strobe
// and the countdown clear for the display timer, stopping once the countdown expires.
module second_pulse_ctrl #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_key_n,
    input  logic pause_key_n,
    input  logic game_finished,
    output logic one_second_pulse,
    output logic timer_clear,
    output logic running,
    output logic paused,
    output logic expired
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_EXPIRED
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;

    logic start_s1_q, start_s2_q, start_lvl_q, start_ev_q;
    logic pause_s1_q, pause_s2_q, pause_lvl_q, pause_ev_q;

    logic clear_q, clear_d, clear_dly_q;
    logic pulse_q, pulse_d;
    logic running_q, paused_q, expired_q;
    logic restart_c;
    logic finished_c;

    // Two-flop synchronisers plus registered press-edge (1->0) detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1_q  <= 1'b1;
            start_s2_q  <= 1'b1;
            start_lvl_q <= 1'b1;
            start_ev_q  <= 1'b0;
            pause_s1_q  <= 1'b1;
            pause_s2_q  <= 1'b1;
            pause_lvl_q <= 1'b1;
            pause_ev_q  <= 1'b0;
        end else begin
            start_s1_q  <= start_key_n;
            start_s2_q  <= start_s1_q;
            start_lvl_q <= start_s2_q;
            start_ev_q  <= start_lvl_q & ~start_s2_q;
            pause_s1_q  <= pause_key_n;
            pause_s2_q  <= pause_s1_q;
            pause_lvl_q <= pause_s2_q;
            pause_ev_q  <= pause_lvl_q & ~pause_s2_q;
        end
    end

    // A stale finished flag is masked while the clear propagates downstream
    assign finished_c = game_finished & ~clear_q & ~clear_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            clear_q     <= 1'b0;
            clear_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            clear_q     <= clear_d;
            clear_dly_q <= clear_q;
            pulse_q     <= pulse_d;
            running_q   <= (state_d == ST_RUNNING);
            paused_q    <= (state_d == ST_PAUSED);
            expired_q   <= (state_d == ST_EXPIRED);
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        clear_d   = 1'b0;
        pulse_d   = 1'b0;
        restart_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ev_q) restart_c = 1'b1;
            end
            ST_RUNNING: begin
                if (finished_c) begin
                    state_d = ST_EXPIRED;
                end else if (start_ev_q) begin
                    restart_c = 1'b1;
                end else if (pause_ev_q) begin
                    state_d = ST_PAUSED;
                end else if (presc_q == CNT_MAX) begin
                    presc_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            ST_PAUSED: begin
                if (start_ev_q) begin
                    restart_c = 1'b1;
                end else if (pause_ev_q) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_EXPIRED: begin
                if (start_ev_q) restart_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        if (restart_c) begin
            state_d = ST_RUNNING;
            presc_d = '0;
            clear_d = 1'b1;
        end
    end

    assign one_second_pulse = pulse_q;
    assign timer_clear      = clear_q;
    assign running          = running_q;
    assign paused           = paused_q;
    assign expired          = expired_q;

endmodule

// File: tb/tb_second_pulse_ctrl.sv
// Directed bench for second_pulse_ctrl with CLK_HZ = 10; outputs sampled on the falling edge.
module tb_second_pulse_ctrl;

    localparam int unsigned CLK_HZ = 10;

    logic clk           = 1'b0;
    logic rst_n         = 1'b0;
    logic start_key_n   = 1'b1;
    logic pause_key_n   = 1'b1;
    logic game_finished = 1'b0;
    logic one_second_pulse, timer_clear, running, paused, expired;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    second_pulse_ctrl #(.CLK_HZ(CLK_HZ)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_key_n     (start_key_n),
        .pause_key_n     (pause_key_n),
        .game_finished   (game_finished),
        .one_second_pulse(one_second_pulse),
        .timer_clear     (timer_clear),
        .running         (running),
        .paused          (paused),
        .expired         (expired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] status();
        return 32'({running, paused, expired});
    endfunction

    // Expects the strobe exactly n samples from now and nowhere before it
    task automatic wait_pulse(input string tag, input int n);
        int early = 0;
        for (int i = 1; i < n; i++) begin
            tick(1);
            if (one_second_pulse) early++;
        end
        tick(1);
        check({tag, "_early"}, early, 0);
        check({tag, "_strobe"}, 32'(one_second_pulse), 1);
    endtask

    // Start press: event after 3 edges, clear and RUNNING on the 4th
    task automatic start_press(input string tag);
        start_key_n = 1'b0;
        tick(3);
        check({tag, "_clear_early"}, 32'(timer_clear), 0);
        tick(1);
        check({tag, "_clear"}, 32'(timer_clear), 1);
        check({tag, "_running"}, status(), 32'b100);
        start_key_n = 1'b1;
    endtask

    task automatic pause_press();
        pause_key_n = 1'b0;
        tick(4);
        pause_key_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int bad;

        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("reset_status", status(), 0);
        check("reset_pulse", 32'(one_second_pulse), 0);
        check("reset_clear", 32'(timer_clear), 0);

        // Basic run: strobes every 10 cycles after the clear
        start_press("t1");
        wait_pulse("t1_p1", 10);
        wait_pulse("t1_p2", 10);
        wait_pulse("t1_p3", 10);

        // Pause with prescaler at 4, long hold, resume: 6 running cycles remain
        tick(1);
        pause_key_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (one_second_pulse) cnt++;
        end
        pause_key_n = 1'b1;
        check("t2_paused", status(), 32'b010);
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            tick(1);
            if (one_second_pulse || !paused) bad++;
        end
        check("t2_hold", bad + cnt, 0);
        pause_key_n = 1'b0;
        tick(3);
        check("t2_still_paused", status(), 32'b010);
        tick(1);
        check("t2_resumed", status(), 32'b100);
        pause_key_n = 1'b1;
        wait_pulse("t2_resume", 6);

        // Pause landing on the wrap cycle suppresses that strobe until resume
        tick(6);
        pause_key_n = 1'b0;
        tick(4);
        pause_key_n = 1'b1;
        check("wrap_paused", status(), 32'b010);
        check("wrap_suppressed", 32'(one_second_pulse), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (one_second_pulse) cnt++;
        end
        check("wrap_hold", cnt, 0);
        pause_key_n = 1'b0;
        tick(4);
        pause_key_n = 1'b1;
        check("wrap_resumed", status(), 32'b100);
        check("wrap_no_early", 32'(one_second_pulse), 0);
        tick(1);
        check("wrap_resume_strobe", 32'(one_second_pulse), 1);

        // Expiry two cycles after a strobe, then restart with finished still high
        tick(2);
        game_finished = 1'b1;
        tick(1);
        check("t3_expired", status(), 32'b001);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (one_second_pulse || !expired) cnt++;
        end
        check("t3_hold", cnt, 0);
        start_press("t3");
        tick(1);
        check("t3_window0", status(), 32'b100);
        tick(1);
        check("t3_window1", status(), 32'b100);
        game_finished = 1'b0;
        wait_pulse("t3_restart", 8);

        // Start and pause together while PAUSED act as restart only
        tick(1);
        pause_press();
        check("t4_paused", status(), 32'b010);
        tick(5);
        pause_key_n = 1'b0;
        start_press("t4");
        pause_key_n = 1'b1;
        wait_pulse("t4_restart", 10);

        // Reset on a strobe cycle drops it and returns to IDLE at once
        wait_pulse("t6_pre", 10);
        rst_n = 1'b0;
        #1;
        check("t6_pulse", 32'(one_second_pulse), 0);
        check("t6_status", status(), 0);
        check("t6_clear", 32'(timer_clear), 0);
        tick(1);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (one_second_pulse || timer_clear || status() != 0) cnt++;
        end
        check("t6_idle", cnt, 0);

        // Pause press in IDLE is ignored
        pause_key_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 5) pause_key_n = 1'b1;
            if (timer_clear || status() != 0) cnt++;
        end
        check("t5_idle_pause", cnt, 0);

        // Long start hold gives exactly one clear
        start_key_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (timer_clear) cnt++;
        end
        start_key_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (timer_clear) cnt++;
        end
        check("t5_one_clear", cnt, 1);
        check("t5_running", status(), 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
